// File: rtl/timer_pkg.sv
// Shared types, digit limits and preset clamping for the MM:SS countdown.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] v,
    input logic [3:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [15:0] clamp_preset(
    input logic [15:0] p
  );
    return {clamp_digit(p[15:12], MIN_TENS_MAX),
            clamp_digit(p[11:8],  MIN_ONES_MAX),
            clamp_digit(p[7:4],   SEC_TENS_MAX),
            clamp_digit(p[3:0],   SEC_ONES_MAX)};
  endfunction

endpackage

// File: rtl/timer_digit.sv
// One BCD down-counter digit; wraps to its limit and borrows from above.
module timer_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       decrease,
  input  logic [3:0] limit,
  output logic [3:0] val,
  output logic       borrow
);

  // Reset value is the loaded preset, not zero.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      val <= load_val;
    end else if (decrease) begin
      val <= (val == 4'd0) ? limit : val - 4'd1;
    end
  end

  assign borrow = decrease && (val == 4'd0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Run/pause/done sequencing, 1 Hz prescaler and borrow chain for MM:SS.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pause,
  input  logic        clear,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic [1:0]  state,
  output logic        tick,
  output logic        done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          done_q;

  logic [15:0] load_val;
  logic [3:0]  dec;
  logic [3:0]  brw;
  logic [3:0]  lim [4];
  logic        last_step;

  assign load_val = clamp_preset(preset);

  assign lim[0] = SEC_ONES_MAX;
  assign lim[1] = SEC_TENS_MAX;
  assign lim[2] = MIN_ONES_MAX;
  assign lim[3] = MIN_TENS_MAX;

  assign tick = (state_q == RUN) && (cnt_q == LAST);

  // A digit steps only when every lower digit borrows.
  assign dec[0] = tick;
  assign dec[1] = brw[0];
  assign dec[2] = brw[1];
  assign dec[3] = brw[2];

  for (genvar i = 0; i < 4; i++) begin : g_dig
    timer_digit u_dig (
      .clk      (clk),
      .rst      (rst),
      .load     (clear),
      .load_val (load_val[4*i +: 4]),
      .decrease (dec[i]),
      .limit    (lim[i]),
      .val      (digits[4*i +: 4]),
      .borrow   (brw[i])
    );
  end

  assign last_step = tick && (digits == 16'h0001);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_pause && (digits != 16'h0000)) state_d = RUN;
      end
      RUN: begin
        if (last_step)        state_d = DONE;
        else if (start_pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_pause) state_d = RUN;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    cnt_d = '0;
    unique case (state_q)
      RUN:     cnt_d = tick ? '0 : cnt_q + CW'(1);
      PAUSE:   cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl with TICK_DIV=4: vector table plus sequences.
module tb_countdown_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_pause = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] preset = 16'h0003;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        tick;
  logic        done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [1:0]  s;
    logic        dn;
    logic        t;
  } exp_t;

  typedef struct {
    logic [15:0] pre;
    logic [15:0] d;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  countdown_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pause (start_pause),
    .clear       (clear),
    .preset      (preset),
    .digits      (digits),
    .state       (state),
    .tick        (tick),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs; expectation is for the following cycle.
  task automatic cyc(input logic r, input logic sp, input logic clr,
                     input logic [15:0] ed, input logic [1:0] es,
                     input logic edn, input logic et, input string nm);
    exp_t e;
    rst = r;
    start_pause = sp;
    clear = clr;
    sb.push_back('{nm, ed, es, edn, et});
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_pause = 1'b0;
    clear = 1'b0;
    e = sb.pop_front();
    chk({e.name, ".digits"}, digits, e.d);
    chk({e.name, ".state"}, {14'd0, state}, {14'd0, e.s});
    chk({e.name, ".done"}, {15'd0, done}, {15'd0, e.dn});
    chk({e.name, ".tick"}, {15'd0, tick}, {15'd0, e.t});
  endtask

  initial begin
    vecs[0] = '{16'h7F9C, 16'h5959};
    vecs[1] = '{16'h0003, 16'h0003};
    vecs[2] = '{16'h1000, 16'h1000};
    vecs[3] = '{16'h9999, 16'h5959};
    vecs[4] = '{16'h6A5B, 16'h5959};
    vecs[5] = '{16'h0000, 16'h0000};
    vecs[6] = '{16'h2345, 16'h2345};
    vecs[7] = '{16'h0870, 16'h0850};

    // reset then count 00:03 down to DONE
    preset = 16'h0003;
    cyc(1, 0, 0, 16'h0003, 2'd0, 0, 0, "reset");
    cyc(0, 1, 0, 16'h0003, 2'd1, 0, 0, "start");
    for (int k = 2; k <= 12; k++) begin
      logic [15:0] ed;
      ed = 16'(3 - (k - 1) / 4);
      cyc(0, 0, 0, ed, 2'd1, 0, (k % 4 == 0), "run3");
    end
    cyc(0, 0, 0, 16'h0000, 2'd3, 1, 0, "reach_done");
    for (int k = 0; k < 20; k++)
      cyc(0, (k == 5), 0, 16'h0000, 2'd3, 1, 0, "hold_done");

    // 10:00 -> 09:59 borrows through three digits
    preset = 16'h1000;
    cyc(0, 0, 1, 16'h1000, 2'd0, 0, 0, "load1000");
    cyc(0, 1, 0, 16'h1000, 2'd1, 0, 0, "start1000");
    cyc(0, 0, 0, 16'h1000, 2'd1, 0, 0, "c2");
    cyc(0, 0, 0, 16'h1000, 2'd1, 0, 0, "c3");
    cyc(0, 0, 0, 16'h1000, 2'd1, 0, 1, "tick1000");
    cyc(0, 0, 0, 16'h0959, 2'd1, 0, 0, "borrow");

    // clamp table, loaded via clear
    foreach (vecs[i]) begin
      preset = vecs[i].pre;
      cyc(0, 0, 1, vecs[i].d, 2'd0, 0, 0, "clamp");
    end

    // pause with prescaler held at 2, resume
    preset = 16'h0005;
    cyc(0, 0, 1, 16'h0005, 2'd0, 0, 0, "load5");
    cyc(0, 1, 0, 16'h0005, 2'd1, 0, 0, "start5");
    cyc(0, 0, 0, 16'h0005, 2'd1, 0, 0, "cnt1");
    cyc(0, 1, 0, 16'h0005, 2'd2, 0, 0, "pause");
    preset = 16'h0042;
    for (int k = 0; k < 50; k++)
      cyc(0, 0, 0, 16'h0005, 2'd2, 0, 0, "paused");
    cyc(0, 1, 0, 16'h0005, 2'd1, 0, 0, "resume");
    cyc(0, 0, 0, 16'h0005, 2'd1, 0, 1, "resume_tick");
    cyc(0, 0, 0, 16'h0004, 2'd1, 0, 0, "after_resume");

    // clear beats start_pause in RUN; new preset taken only now
    cyc(0, 1, 1, 16'h0042, 2'd0, 0, 0, "clr_sp");
    preset = 16'h0000;
    cyc(0, 0, 1, 16'h0000, 2'd0, 0, 0, "load0");
    cyc(0, 1, 0, 16'h0000, 2'd0, 0, 0, "start_zero");

    // mid-run reset reloads preset like clear
    preset = 16'h0031;
    cyc(0, 0, 1, 16'h0031, 2'd0, 0, 0, "load31");
    cyc(0, 1, 0, 16'h0031, 2'd1, 0, 0, "start31");
    preset = 16'h0207;
    cyc(1, 0, 0, 16'h0207, 2'd0, 0, 0, "mid_rst");

    // start_pause coincident with final tick: DONE wins
    preset = 16'h0001;
    cyc(0, 0, 1, 16'h0001, 2'd0, 0, 0, "load1");
    cyc(0, 1, 0, 16'h0001, 2'd1, 0, 0, "start1");
    cyc(0, 0, 0, 16'h0001, 2'd1, 0, 0, "d2");
    cyc(0, 0, 0, 16'h0001, 2'd1, 0, 0, "d3");
    cyc(0, 0, 0, 16'h0001, 2'd1, 0, 1, "d4");
    cyc(0, 1, 0, 16'h0000, 2'd3, 1, 0, "sp_tick_done");
    cyc(0, 0, 0, 16'h0000, 2'd3, 1, 0, "stay_done");
    cyc(0, 0, 1, 16'h0001, 2'd0, 0, 0, "clr_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
